// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy_score BCD score keeper.
package flappy_pkg;

    typedef enum logic [0:0] {PLAY, OVER} state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t        BCD_MAX = 4'd9;
    localparam int unsigned SCORE_W = 12;

    // Packs hundreds/tens/ones into one word; BCD orders the same as binary.
    function automatic logic [SCORE_W-1:0] pack_score(bcd_t hundreds, bcd_t tens, bcd_t ones);
        return {hundreds, tens, ones};
    endfunction

endpackage

// File: rtl/flappy_score_if.sv
// Game-event inputs and score/best/status outputs of the flappy_score block.
interface flappy_score_if;
    import flappy_pkg::*;

    logic pass;
    logic game_over;
    logic restart;
    bcd_t counter1;
    bcd_t counter2;
    bcd_t counter3;
    bcd_t best1;
    bcd_t best2;
    bcd_t best3;
    logic playing;
    logic new_best;

    // Game logic side: drives events, observes score.
    modport master (
        output pass, game_over, restart,
        input  counter1, counter2, counter3, best1, best2, best3, playing, new_best
    );

    // Score keeper side.
    modport slave (
        input  pass, game_over, restart,
        output counter1, counter2, counter3, best1, best2, best3, playing, new_best
    );

endinterface

// File: rtl/bcd_digit.sv
// One registered BCD digit; chained by carry_out to build a multi-digit counter.
module bcd_digit
    import flappy_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    input  logic sat,
    output bcd_t digit,
    output logic carry_out
);

    bcd_t digit_q;
    bcd_t digit_d;

    // Next digit: clear wins, then increment with wrap or hold at 9 when saturating.
    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (en) begin
            if (digit_q == BCD_MAX) begin
                digit_d = sat ? BCD_MAX : '0;
            end else begin
                digit_d = digit_q + 4'd1;
            end
        end
    end

    // Digit register with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit     = digit_q;
    assign carry_out = en & (digit_q == BCD_MAX);

endmodule

// File: rtl/flappy_score.sv
// Three-digit BCD score keeper: pass edge detect, PLAY/OVER FSM, best-score register.
module flappy_score
    import flappy_pkg::*;
#(
    parameter bit SAT_ENABLE = 1'b1
) (
    input logic          Clock,
    input logic          Reset,
    flappy_score_if.slave bus
);

    state_t state_q;
    state_t state_d;
    logic   pass_q;
    bcd_t   best1_q, best2_q, best3_q;
    logic   new_best_q;
    logic   new_best_d;
    logic   best_upd;

    bcd_t   dig1, dig2, dig3;
    logic   carry1, carry2, carry3;
    logic   inc;
    logic   clr;
    logic   at_max;
    logic   sat;

    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] best;

    // Hundreds carry only matters for wrap, which the digits already handle.
    logic unused_carry;
    assign unused_carry = carry3;

    assign score  = pack_score(dig3, dig2, dig1);
    assign best   = pack_score(best3_q, best2_q, best1_q);
    assign at_max = (dig3 == BCD_MAX) && (dig2 == BCD_MAX) && (dig1 == BCD_MAX);
    assign sat    = SAT_ENABLE && at_max;

    // Rising edge of pass counts only while playing and not colliding this cycle.
    assign inc = bus.pass & ~pass_q & (state_q == PLAY) & ~bus.game_over;
    assign clr = (state_q == OVER) & bus.restart;

    bcd_digit u_ones (
        .Clock     (Clock),
        .Reset     (Reset),
        .clr       (clr),
        .en        (inc),
        .sat       (sat),
        .digit     (dig1),
        .carry_out (carry1)
    );

    bcd_digit u_tens (
        .Clock     (Clock),
        .Reset     (Reset),
        .clr       (clr),
        .en        (carry1),
        .sat       (sat),
        .digit     (dig2),
        .carry_out (carry2)
    );

    bcd_digit u_hundreds (
        .Clock     (Clock),
        .Reset     (Reset),
        .clr       (clr),
        .en        (carry2),
        .sat       (sat),
        .digit     (dig3),
        .carry_out (carry3)
    );

    // Next-state, best-score capture and new_best flag.
    always_comb begin
        state_d    = state_q;
        new_best_d = new_best_q;
        best_upd   = 1'b0;
        unique case (state_q)
            PLAY: begin
                if (bus.game_over) begin
                    state_d = OVER;
                    if (score > best) begin
                        best_upd   = 1'b1;
                        new_best_d = 1'b1;
                    end else begin
                        new_best_d = 1'b0;
                    end
                end
            end
            OVER: begin
                // Restart beats a simultaneous game_over.
                if (bus.restart) begin
                    state_d    = PLAY;
                    new_best_d = 1'b0;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    // State, edge-detect and best-score registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= PLAY;
            pass_q     <= 1'b0;
            best1_q    <= '0;
            best2_q    <= '0;
            best3_q    <= '0;
            new_best_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pass_q     <= bus.pass;
            new_best_q <= new_best_d;
            if (best_upd) begin
                best1_q <= dig1;
                best2_q <= dig2;
                best3_q <= dig3;
            end
        end
    end

    assign bus.counter1 = dig1;
    assign bus.counter2 = dig2;
    assign bus.counter3 = dig3;
    assign bus.best1    = best1_q;
    assign bus.best2    = best2_q;
    assign bus.best3    = best3_q;
    assign bus.playing  = (state_q == PLAY);
    assign bus.new_best = new_best_q;

endmodule

// File: tb/tb_flappy_score.sv
// Bench for flappy_score: saturating and wrapping instances driven in lockstep,
// checked every cycle against a behavioural integer model via a scoreboard queue.
module tb_flappy_score;

    typedef logic [25:0] obs_t;
    typedef struct packed {
        obs_t s;
        obs_t w;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    flappy_score_if if_sat ();
    flappy_score_if if_wrap ();

    flappy_score #(.SAT_ENABLE(1'b1)) dut_sat (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (if_sat)
    );

    flappy_score #(.SAT_ENABLE(1'b0)) dut_wrap (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (if_wrap)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";
    exp_t  exp_q[$];

    // Model state, index 0 = saturating, 1 = wrapping.
    int m_score[2];
    int m_best[2];
    bit m_play[2];
    bit m_nb[2];
    bit m_pq[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s/%s: got %h want %h", phase, tag, got, want);
        end
    endtask

    function automatic obs_t pack(input int sc, input int bs, input bit pl, input bit nb);
        return {4'(sc / 100), 4'((sc / 10) % 10), 4'(sc % 10),
                4'(bs / 100), 4'((bs / 10) % 10), 4'(bs % 10), pl, nb};
    endfunction

    function automatic obs_t obs_sat();
        return {if_sat.counter3, if_sat.counter2, if_sat.counter1,
                if_sat.best3, if_sat.best2, if_sat.best1, if_sat.playing, if_sat.new_best};
    endfunction

    function automatic obs_t obs_wrap();
        return {if_wrap.counter3, if_wrap.counter2, if_wrap.counter1,
                if_wrap.best3, if_wrap.best2, if_wrap.best1, if_wrap.playing, if_wrap.new_best};
    endfunction

    task automatic model(input bit p, input bit go, input bit rs, input bit rst);
        bit inc;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_score[k] = 0;
                m_best[k]  = 0;
                m_nb[k]    = 0;
                m_play[k]  = 1;
                m_pq[k]    = 0;
            end else begin
                inc = p && !m_pq[k] && m_play[k] && !go;
                if (m_play[k]) begin
                    if (go) begin
                        if (m_score[k] > m_best[k]) begin
                            m_best[k] = m_score[k];
                            m_nb[k]   = 1;
                        end else begin
                            m_nb[k] = 0;
                        end
                        m_play[k] = 0;
                    end else if (inc) begin
                        if (m_score[k] == 999) m_score[k] = (k == 0) ? 999 : 0;
                        else                   m_score[k] = m_score[k] + 1;
                    end
                end else if (rs) begin
                    m_play[k]  = 1;
                    m_score[k] = 0;
                    m_nb[k]    = 0;
                end
                m_pq[k] = p;
            end
        end
    endtask

    // One clock: drive, predict, push; then sample after the edge, pop and compare.
    task automatic step(input bit p, input bit go, input bit rs, input bit rst);
        exp_t e;
        if_sat.pass       = p;
        if_sat.game_over  = go;
        if_sat.restart    = rs;
        if_wrap.pass      = p;
        if_wrap.game_over = go;
        if_wrap.restart   = rs;
        Reset             = rst;
        model(p, go, rs, rst);
        e.s = pack(m_score[0], m_best[0], m_play[0], m_nb[0]);
        e.w = pack(m_score[1], m_best[1], m_play[1], m_nb[1]);
        exp_q.push_back(e);
        @(posedge Clock);
        #1;
        e = exp_q.pop_front();
        check_eq("sat_cycle", 32'(obs_sat()), 32'(e.s));
        check_eq("wrap_cycle", 32'(obs_wrap()), 32'(e.w));
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    function automatic logic [31:0] score_sat();
        return 32'({if_sat.counter3, if_sat.counter2, if_sat.counter1});
    endfunction

    function automatic logic [31:0] best_sat();
        return 32'({if_sat.best3, if_sat.best2, if_sat.best1});
    endfunction

    initial begin
        phase = "reset";
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("playing", 32'(if_sat.playing), 32'd1);

        phase = "hold";
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("first_edge", score_sat(), 32'h001);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("held_once", score_sat(), 32'h001);

        phase = "count123";
        step(1'b0, 1'b0, 1'b0, 1'b1);
        pulses(123);
        check_eq("score", score_sat(), 32'h123);

        phase = "over42";
        step(1'b0, 1'b0, 1'b0, 1'b1);
        pulses(42);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("playing", 32'(if_sat.playing), 32'd0);
        check_eq("best", best_sat(), 32'h042);
        check_eq("new_best", 32'(if_sat.new_best), 32'd1);
        pulses(5);
        check_eq("frozen", score_sat(), 32'h042);

        phase = "game17";
        step(1'b0, 1'b0, 1'b1, 1'b0);
        pulses(17);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("best_kept", best_sat(), 32'h042);
        check_eq("new_best", 32'(if_sat.new_best), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("restart_score", score_sat(), 32'h000);
        check_eq("restart_best", best_sat(), 32'h042);
        check_eq("restart_playing", 32'(if_sat.playing), 32'd1);

        phase = "pass_at_restart";
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("no_count", score_sat(), 32'h000);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("recount", score_sat(), 32'h001);

        phase = "edge_and_go";
        step(1'b0, 1'b0, 1'b0, 1'b1);
        pulses(7);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("score", score_sat(), 32'h007);
        check_eq("best", best_sat(), 32'h007);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("reset_in_over", 32'(obs_sat()), 32'(pack(0, 0, 1'b1, 1'b0)));

        phase = "limit";
        pulses(999);
        check_eq("sat_999", score_sat(), 32'h999);
        pulses(1);
        check_eq("wrap_000", 32'({if_wrap.counter3, if_wrap.counter2, if_wrap.counter1}), 32'h000);
        pulses(5);
        check_eq("sat_hold", score_sat(), 32'h999);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
